decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and register count at 32.
REQ-002 The block SHALL have the port clk, input, 1 bit, which is the pipeline clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit, which is the asynchronous, active-high reset.
REQ-004 The block SHALL have the port flush, input, 1 bit, which inserts a bubble into the ID/EX register.
REQ-005 The block SHALL have the ports instrD (input, 32 bits, instruction from fetch) and PCD (input, 32 bits, PC of instrD).
REQ-006 The block SHALL have the write-back ports regWriteW (input, 1 bit), rdW (input, 5 bits) and resultW (input, 32 bits).
REQ-007 The block SHALL have the registered data outputs rd1E (32 bits), rd2E (32 bits), immE (32 bits) and PCE (32 bits).
REQ-008 The block SHALL have the registered index outputs rs1E, rs2E and rdE, each 5 bits.
REQ-009 The block SHALL have the registered control outputs regWriteE, memWriteE, branchE, jumpE, aluSrcE and illegalE, each 1 bit.
REQ-010 The block SHALL have the registered control outputs resultSrcE (2 bits), aluControlE (4 bits) and funct3E (3 bits).

Function
REQ-011 The register file SHALL be 32 entries of 32 bits, written on the rising clk edge when regWriteW=1 and rdW!=0.
REQ-012 Register x0 SHALL read as 0 at all times, and writes to x0 SHALL be ignored.
REQ-013 Register reads SHALL be combinational on instrD[19:15] and instrD[24:20], and SHALL return resultW when regWriteW=1, rdW!=0 and rdW equals the read index (write-through bypass).
REQ-014 Immediates SHALL be sign-extended from bit 31, per opcode:
- I-type (0010011, 0000011): instr[31:20].
- S-type (0100011): {instr[31:25], instr[11:7]}.
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- U-type (0110111): {instr[31:12], 12'b0}.
REQ-015 The aluControl encoding SHALL be: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001, PASSB=1010.
REQ-016 Control decode for R-type (0110011) SHALL be regWrite=1, aluSrc=0, resultSrc=00, with aluControl selected from funct3 and funct7[5] (SUB and SRA when funct7[5]=1).
REQ-017 Control decode for I-ALU (0010011) SHALL be regWrite=1 and aluSrc=1; funct7[5] SHALL be honoured only for funct3=101 (SRAI); ADDI with funct7[5]=1 SHALL be ADD.
REQ-018 Control decode for LW (0000011) SHALL be regWrite=1, aluSrc=1, resultSrc=01, aluControl=ADD.
REQ-019 Control decode for SW (0100011) SHALL be memWrite=1, aluSrc=1, aluControl=ADD.
REQ-020 Control decode for branch (1100011) SHALL be branch=1, aluSrc=0, aluControl=SUB, with funct3 passed through in funct3E.
REQ-021 Control decode for JAL (1101111) SHALL be jump=1, regWrite=1, resultSrc=10 (PC+4).
REQ-022 Control decode for LUI (0110111) SHALL be regWrite=1, aluSrc=1, aluControl=PASSB.
REQ-023 instrD=0x00000000 (a flushed fetch slot) SHALL decode as a bubble: all controls 0 and illegalE=0.
REQ-024 Any other opcode SHALL decode with all controls 0 and illegalE=1.
REQ-025 Every E-suffixed output SHALL be registered in the ID/EX register, giving 1-cycle latency from instrD/PCD.
REQ-026 flush=1 at a clock edge SHALL load all ID/EX fields with 0.
REQ-027 A register-file write occurring in the same cycle as flush SHALL still take effect.

Reset
REQ-028 rst=1 SHALL asynchronously clear all ID/EX outputs and all 32 registers to 0.
REQ-029 rst=1 SHALL block register-file writes while asserted.
REQ-030 After rst deasserts, the first clock edge SHALL capture the current instrD normally.

Verification
REQ-031 Bench scenario, ADDI decode: after reset, instrD=0x00500093 (addi x1,x0,5), PCD=0x10 -> next edge: regWriteE=1, aluSrcE=1, immE=5, rdE=1, aluControlE=0000, PCE=0x10.
REQ-032 Bench scenario, write-through bypass: regWriteW=1, rdW=3, resultW=0xDEADBEEF, with instrD=0x00018133 (add x2,x3,x0) in the same cycle -> rd1E=0xDEADBEEF.
REQ-033 Bench scenario, x0 guard: regWriteW=1, rdW=0, resultW=0x1234 -> a subsequent read of x0 returns 0.
REQ-034 Bench scenario, branch immediate: instrD=0xFE000EE3 (beq x0,x0,-4) -> branchE=1, immE=0xFFFFFFFC, aluControlE=0001, funct3E=000.
REQ-035 Bench scenario, flush and bubble: flush=1 with a valid SW in instrD -> all E outputs 0; instrD=0 -> illegalE=0; instrD=0x0000007F -> illegalE=1.
REQ-036 Bench scenario, mid-run reset: rst pulse mid-run -> outputs 0 immediately without waiting for a clock edge, and previously written registers read 0.

Source files
------------

// File: rtl/decode.sv
// Instruction-decode stage: register file with write-through bypass, immediate and
// control decode, and the ID/EX pipeline register that feeds execute.
module decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] instrD,
   input  logic [31:0] PCD,
   input  logic        regWriteW,
   input  logic [4:0]  rdW,
   input  logic [31:0] resultW,
   output logic [31:0] rd1E,
   output logic [31:0] rd2E,
   output logic [31:0] immE,
   output logic [31:0] PCE,
   output logic [4:0]  rs1E,
   output logic [4:0]  rs2E,
   output logic [4:0]  rdE,
   output logic        regWriteE,
   output logic        memWriteE,
   output logic        branchE,
   output logic        jumpE,
   output logic        aluSrcE,
   output logic        illegalE,
   output logic [1:0]  resultSrcE,
   output logic [3:0]  aluControlE,
   output logic [2:0]  funct3E
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
      logic        illegal;
      logic [1:0]  result_src;
      logic [3:0]  alu_control;
      logic [2:0]  funct3;
   } idex_t;

   // alt selects SUB/SRA; callers mask it where funct7[5] must be ignored
   function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   logic [31:0] rf_q [32];
   logic        wb_en_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [31:0] rd1_s;
   logic [31:0] rd2_s;
   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   idex_t       dec_s;
   idex_t       idex_d;
   idex_t       idex_q;

   assign wb_en_s  = regWriteW && (rdW != 5'd0);
   assign rs1_s    = instrD[19:15];
   assign rs2_s    = instrD[24:20];
   assign opcode_s = instrD[6:0];
   assign funct3_s = instrD[14:12];

   // Register file: x0 is never written; reset clears every entry and holds off writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'd0;
         end
      end else if (wb_en_s) begin
         rf_q[rdW] <= resultW;
      end
   end

   // Combinational reads with write-back bypass and hard-wired x0
   always_comb begin
      rd1_s = 32'd0;
      rd2_s = 32'd0;
      if (rs1_s == 5'd0) begin
         rd1_s = 32'd0;
      end else if (wb_en_s && (rdW == rs1_s)) begin
         rd1_s = resultW;
      end else begin
         rd1_s = rf_q[rs1_s];
      end
      if (rs2_s == 5'd0) begin
         rd2_s = 32'd0;
      end else if (wb_en_s && (rdW == rs2_s)) begin
         rd2_s = resultW;
      end else begin
         rd2_s = rf_q[rs2_s];
      end
   end

   // Immediate and control decode; an all-zero word is a bubble, not an illegal op
   always_comb begin
      dec_s     = '0;
      dec_s.rd1 = rd1_s;
      dec_s.rd2 = rd2_s;
      dec_s.pc  = PCD;
      dec_s.rs1 = rs1_s;
      dec_s.rs2 = rs2_s;
      dec_s.rd  = instrD[11:7];
      if (instrD == 32'd0) begin
         dec_s.illegal = 1'b0;
      end else begin
         dec_s.funct3 = funct3_s;
         case (opcode_s)
            OP_R: begin
               dec_s.reg_write   = 1'b1;
               dec_s.alu_control = alu_sel(funct3_s, instrD[30]);
            end
            OP_I: begin
               dec_s.reg_write   = 1'b1;
               dec_s.alu_src     = 1'b1;
               dec_s.imm         = {{20{instrD[31]}}, instrD[31:20]};
               dec_s.alu_control = alu_sel(funct3_s, instrD[30] & (funct3_s == 3'b101));
            end
            OP_LW: begin
               dec_s.reg_write   = 1'b1;
               dec_s.alu_src     = 1'b1;
               dec_s.result_src  = 2'b01;
               dec_s.imm         = {{20{instrD[31]}}, instrD[31:20]};
               dec_s.alu_control = ALU_ADD;
            end
            OP_SW: begin
               dec_s.mem_write   = 1'b1;
               dec_s.alu_src     = 1'b1;
               dec_s.imm         = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
               dec_s.alu_control = ALU_ADD;
            end
            OP_B: begin
               dec_s.branch      = 1'b1;
               dec_s.alu_control = ALU_SUB;
               dec_s.imm         = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            end
            OP_JAL: begin
               dec_s.jump       = 1'b1;
               dec_s.reg_write  = 1'b1;
               dec_s.result_src = 2'b10;
               dec_s.imm        = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            end
            OP_LUI: begin
               dec_s.reg_write   = 1'b1;
               dec_s.alu_src     = 1'b1;
               dec_s.alu_control = ALU_PASSB;
               dec_s.imm         = {instrD[31:12], 12'd0};
            end
            default: begin
               dec_s.funct3  = 3'd0;
               dec_s.illegal = 1'b1;
            end
         endcase
      end
   end

   assign idex_d = flush ? idex_t'('0) : dec_s;

   // ID/EX pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign rd1E        = idex_q.rd1;
   assign rd2E        = idex_q.rd2;
   assign immE        = idex_q.imm;
   assign PCE         = idex_q.pc;
   assign rs1E        = idex_q.rs1;
   assign rs2E        = idex_q.rs2;
   assign rdE         = idex_q.rd;
   assign regWriteE   = idex_q.reg_write;
   assign memWriteE   = idex_q.mem_write;
   assign branchE     = idex_q.branch;
   assign jumpE       = idex_q.jump;
   assign aluSrcE     = idex_q.alu_src;
   assign illegalE    = idex_q.illegal;
   assign resultSrcE  = idex_q.result_src;
   assign aluControlE = idex_q.alu_control;
   assign funct3E     = idex_q.funct3;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus randomized instructions
// checked against an arithmetic reference model of the decode rules.
module tb_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] instrD;
   logic [31:0] PCD;
   logic        regWriteW;
   logic [4:0]  rdW;
   logic [31:0] resultW;
   logic [31:0] rd1E, rd2E, immE, PCE;
   logic [4:0]  rs1E, rs2E, rdE;
   logic        regWriteE, memWriteE, branchE, jumpE, aluSrcE, illegalE;
   logic [1:0]  resultSrcE;
   logic [3:0]  aluControlE;
   logic [2:0]  funct3E;

   int checks = 0;
   int errors = 0;
   logic [31:0] mrf [32];

   typedef struct {
      logic [31:0] rd1, rd2, imm, pc;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mw, br, jp, src, ill;
      logic [1:0]  rs;
      logic [3:0]  alu;
      logic [2:0]  f3;
   } exp_t;

   decode dut (
      .clk(clk), .rst(rst), .flush(flush), .instrD(instrD), .PCD(PCD),
      .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW),
      .rd1E(rd1E), .rd2E(rd2E), .immE(immE), .PCE(PCE),
      .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
      .regWriteE(regWriteE), .memWriteE(memWriteE), .branchE(branchE), .jumpE(jumpE),
      .aluSrcE(aluSrcE), .illegalE(illegalE), .resultSrcE(resultSrcE),
      .aluControlE(aluControlE), .funct3E(funct3E)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t zero_exp();
      exp_t e;
      e.rd1 = 32'd0; e.rd2 = 32'd0; e.imm = 32'd0; e.pc = 32'd0;
      e.rs1 = 5'd0; e.rs2 = 5'd0; e.rd = 5'd0;
      e.rw = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0; e.src = 1'b0; e.ill = 1'b0;
      e.rs = 2'd0; e.alu = 4'd0; e.f3 = 3'd0;
      return e;
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (regWriteW && rdW == idx) return resultW;
      return mrf[idx];
   endfunction

   // ALU code names: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9
   function automatic logic [3:0] ref_alu(input int f3, input bit alt);
      int code;
      case (f3)
         0: code = alt ? 1 : 0;
         1: code = 7;
         2: code = 5;
         3: code = 6;
         4: code = 4;
         5: code = alt ? 9 : 8;
         6: code = 3;
         default: code = 2;
      endcase
      return 4'(code);
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      int s, f3, imm;
      e = zero_exp();
      if (flush) return e;
      s = int'(ins);
      f3 = int'(ins[14:12]);
      imm = 0;
      e.pc = pc;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.rd1 = ref_read(ins[19:15]);
      e.rd2 = ref_read(ins[24:20]);
      if (ins == 32'd0) return e;
      e.f3 = ins[14:12];
      case (ins[6:0])
         7'h33: begin e.rw = 1; e.alu = ref_alu(f3, ins[30]); end
         7'h13: begin e.rw = 1; e.src = 1; imm = s >>> 20; e.alu = ref_alu(f3, (f3 == 5) && ins[30]); end
         7'h03: begin e.rw = 1; e.src = 1; e.rs = 2'd1; imm = s >>> 20; end
         7'h23: begin e.mw = 1; e.src = 1; imm = (s >>> 25) * 32 + int'(ins[11:7]); end
         7'h63: begin
            e.br = 1; e.alu = 4'd1;
            imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         end
         7'h6F: begin
            e.jp = 1; e.rw = 1; e.rs = 2'd2;
            imm = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         end
         7'h37: begin e.rw = 1; e.src = 1; e.alu = 4'd10; imm = int'(ins & 32'hFFFFF000); end
         default: begin e.ill = 1; e.f3 = 3'd0; end
      endcase
      e.imm = 32'(imm);
      return e;
   endfunction

   task automatic check_out(input string c, input exp_t e);
      check_eq({c, ".rd1E"}, rd1E, e.rd1);
      check_eq({c, ".rd2E"}, rd2E, e.rd2);
      check_eq({c, ".immE"}, immE, e.imm);
      check_eq({c, ".PCE"}, PCE, e.pc);
      check_eq({c, ".rs1E"}, 32'(rs1E), 32'(e.rs1));
      check_eq({c, ".rs2E"}, 32'(rs2E), 32'(e.rs2));
      check_eq({c, ".rdE"}, 32'(rdE), 32'(e.rd));
      check_eq({c, ".ctl"}, 32'({regWriteE, memWriteE, branchE, jumpE, aluSrcE, illegalE}),
               32'({e.rw, e.mw, e.br, e.jp, e.src, e.ill}));
      check_eq({c, ".resultSrcE"}, 32'(resultSrcE), 32'(e.rs));
      check_eq({c, ".aluControlE"}, 32'(aluControlE), 32'(e.alu));
      check_eq({c, ".funct3E"}, 32'(funct3E), 32'(e.f3));
   endtask

   // One pipeline cycle: predict, clock, then compare just after the edge
   task automatic step(input string c);
      exp_t e;
      e = model(instrD, PCD);
      if (!rst && regWriteW && rdW != 5'd0) mrf[rdW] = resultW;
      @(posedge clk);
      #1;
      check_out(c, e);
   endtask

   logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h67, 7'h7F};

   initial begin
      logic [31:0] r;
      int k;
      rst = 1'b1; flush = 1'b0; instrD = 32'd0; PCD = 32'd0;
      regWriteW = 1'b1; rdW = 5'd4; resultW = 32'h11111111;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", zero_exp());
      @(negedge clk);
      rst = 1'b0; regWriteW = 1'b0;

      // ADDI decode
      instrD = 32'h00500093; PCD = 32'h10;
      step("addi");
      check_eq("addi.imm", immE, 32'd5);
      check_eq("addi.ctl", 32'({regWriteE, aluSrcE, rdE, aluControlE}), 32'({1'b1, 1'b1, 5'd1, 4'd0}));
      check_eq("addi.pc", PCE, 32'h10);

      // write-through bypass, then the stored value
      instrD = 32'h00018133; PCD = 32'h14;
      regWriteW = 1'b1; rdW = 5'd3; resultW = 32'hDEADBEEF;
      step("bypass");
      check_eq("bypass.rd1", rd1E, 32'hDEADBEEF);
      regWriteW = 1'b0;
      step("stored");
      check_eq("stored.rd1", rd1E, 32'hDEADBEEF);

      // x0 guard
      instrD = 32'h00000133; regWriteW = 1'b1; rdW = 5'd0; resultW = 32'h1234;
      step("x0_wr");
      regWriteW = 1'b0;
      step("x0_rd");
      check_eq("x0.rd1", rd1E, 32'd0);

      // branch immediate
      instrD = 32'hFE000EE3;
      step("beq");
      check_eq("beq.br", 32'(branchE), 32'd1);
      check_eq("beq.imm", immE, 32'hFFFFFFFC);
      check_eq("beq.alu", 32'(aluControlE), 32'd1);
      check_eq("beq.f3", 32'(funct3E), 32'd0);

      // flush over a store, with a concurrent register write that must land
      instrD = 32'h0020A423; flush = 1'b1;
      regWriteW = 1'b1; rdW = 5'd7; resultW = 32'hCAFEF00D;
      step("flush");
      check_eq("flush.imm", immE, 32'd0);
      check_eq("flush.mw", 32'(memWriteE), 32'd0);
      flush = 1'b0; regWriteW = 1'b0;
      instrD = 32'h000380B3;
      step("flush_wr");
      check_eq("flush_wr.rd1", rd1E, 32'hCAFEF00D);
      instrD = 32'h00000000;
      step("bubble");
      check_eq("bubble.ill", 32'(illegalE), 32'd0);
      instrD = 32'h0000007F;
      step("illegal");
      check_eq("illegal.ill", 32'(illegalE), 32'd1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         k = int'($urandom_range(0, 10));
         r = $urandom();
         instrD = (k == 10) ? 32'd0 : {r[31:7], ops[k]};
         PCD = $urandom();
         regWriteW = 1'($urandom_range(0, 1));
         rdW = 5'($urandom_range(0, 31));
         resultW = $urandom();
         flush = ($urandom_range(0, 7) == 0);
         step("rand");
      end

      // mid-run async reset
      flush = 1'b0;
      instrD = 32'h00500093; PCD = 32'h40;
      regWriteW = 1'b1; rdW = 5'd5; resultW = 32'h55AA55AA;
      step("pre_rst");
      check_eq("pre_rst.rw", 32'(regWriteE), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check_out("async_rst", zero_exp());
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      rdW = 5'd1; resultW = 32'h77777777;
      @(posedge clk);
      #1;
      rst = 1'b0; regWriteW = 1'b0;
      instrD = 32'h007280B3; PCD = 32'h44;
      step("post_rst");
      check_eq("post_rst.rd1", rd1E, 32'd0);
      check_eq("post_rst.rd2", rd2E, 32'd0);
      instrD = 32'h00008133;
      step("post_rst_x1");
      check_eq("post_rst_x1.rd1", rd1E, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
